pll_lock_supervisor: RTL and testbench

//  Runs on the 25 MHz board clock, one level above the 9.375 MHz PLL wrapper.

---
 rtl/pll_lock_supervisor_if.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 150 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment (PLL, clk9 domain).
// ready is a level status rather than a handshake: it is high exactly while the supervisor is in RUN.
interface pll_lock_supervisor_if;
    logic        pll_locked;
    logic        clk_mon;
    logic        pll_rst;
    logic        domain_rst;
    logic        ready;
    logic [15:0] meas_edges;
    logic [7:0]  retry_cnt;
    logic [7:0]  lock_lost_cnt;
    logic [2:0]  state_dbg;

    modport master (
        output pll_locked, clk_mon,
        input  pll_rst, domain_rst, ready, meas_edges, retry_cnt, lock_lost_cnt, state_dbg
    );

    modport slave (
        input  pll_locked, clk_mon,
        output pll_rst, domain_rst, ready, meas_edges, retry_cnt, lock_lost_cnt, state_dbg
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, waits for a stable lock, proves the output frequency by edge
// counting on clk25 and holds the clk9 domain in reset until the frequency is proven.
module pll_lock_supervisor #(
    parameter int unsigned PLLRST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned WINDOW        = 4096,
    parameter int unsigned EDGE_MIN      = 1520,
    parameter int unsigned EDGE_MAX      = 1552
) (
    input  logic                  clk25,
    input  logic                  rst,
    pll_lock_supervisor_if.slave  bus
);
    localparam logic [15:0] RST_LAST  = 16'(PLLRST_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);
    localparam logic [15:0] EMIN      = 16'(EDGE_MIN);
    localparam logic [15:0] EMAX      = 16'(EDGE_MAX);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_MEASURE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] t, t_n;
    logic [15:0] e, e_n, e_fin;
    logic [15:0] meas;
    logic [7:0]  retry, lost;
    logic        lk_s1, lk_s2;
    logic        mon_s1, mon_s2, mon_s3;
    logic        pll_rst_q, domain_rst_q, ready_q;
    logic        lk, mon_edge, win_end, in_range;
    logic        retry_inc, lost_inc, meas_load;

    assign lk       = lk_s2;
    // clk_mon is slower than clk25/2, so every PLL rising edge shows up as one s2&~s3 pulse.
    assign mon_edge = mon_s2 & ~mon_s3;
    assign win_end  = (t == WIN_LAST);
    assign e_fin    = (mon_edge && e != 16'hFFFF) ? e + 16'd1 : e;
    assign in_range = (e_fin >= EMIN) && (e_fin <= EMAX);

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        lost_inc  = 1'b0;
        meas_load = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (t == RST_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_n = S_STABLE;
                end else if (t == TO_LAST) begin
                    state_n   = S_RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk)                  state_n = S_WAIT_LOCK;
                else if (t == STB_LAST)   state_n = S_MEASURE;
            end
            S_MEASURE: begin
                meas_load = win_end;
                if (!lk) begin
                    state_n = S_WAIT_LOCK;
                end else if (win_end) begin
                    if (in_range) begin
                        state_n = S_RUN;
                    end else begin
                        state_n   = S_RESET_PLL;
                        retry_inc = 1'b1;
                    end
                end
            end
            S_RUN: begin
                meas_load = win_end;
                // Lock loss wins over a simultaneous bad window.
                if (!lk) begin
                    state_n  = S_WAIT_LOCK;
                    lost_inc = 1'b1;
                end else if (win_end && !in_range) begin
                    state_n   = S_RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            default: state_n = S_RESET_PLL;
        endcase
    end

    // Timer restarts on every state entry and at each window boundary while measuring.
    always_comb begin
        t_n = t + 16'd1;
        e_n = 16'd0;
        if (state_n != state || ((state == S_MEASURE || state == S_RUN) && win_end)) begin
            t_n = 16'd0;
        end
        if (state_n == state && (state == S_MEASURE || state == S_RUN) && !win_end) begin
            e_n = e_fin;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state        <= S_RESET_PLL;
            t            <= 16'd0;
            e            <= 16'd0;
            meas         <= 16'd0;
            retry        <= 8'd0;
            lost         <= 8'd0;
            lk_s1        <= 1'b0;
            lk_s2        <= 1'b0;
            mon_s1       <= 1'b0;
            mon_s2       <= 1'b0;
            mon_s3       <= 1'b0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state        <= state_n;
            t            <= t_n;
            e            <= e_n;
            lk_s1        <= bus.pll_locked;
            lk_s2        <= lk_s1;
            mon_s1       <= bus.clk_mon;
            mon_s2       <= mon_s1;
            mon_s3       <= mon_s2;
            pll_rst_q    <= (state_n == S_RESET_PLL);
            domain_rst_q <= (state_n != S_RUN);
            ready_q      <= (state_n == S_RUN);
            if (meas_load)                  meas  <= e_fin;
            if (retry_inc && retry != 8'hFF) retry <= retry + 8'd1;
            if (lost_inc && lost != 8'hFF)   lost  <= lost + 8'd1;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.domain_rst    = domain_rst_q;
    assign bus.ready         = ready_q;
    assign bus.meas_edges    = meas;
    assign bus.retry_cnt     = retry;
    assign bus.lock_lost_cnt = lost;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized bench for pll_lock_supervisor with scaled-down timing parameters and a
// cycle-level reference model of the lock/measure sequencing.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;
    localparam int P_RST  = 16;
    localparam int P_TO   = 400;
    localparam int P_STB  = 64;
    localparam int P_WIN  = 256;
    localparam int P_EMIN = 92;
    localparam int P_EMAX = 100;

    // ---------------- clock / reset ----------------
    logic clk25 = 1'b0;
    logic rst   = 1'b1;
    always #20 clk25 = ~clk25;

    logic tb_locked = 1'b0;
    logic tb_mon    = 1'b0;

    pll_lock_supervisor_if bus();
    assign bus.pll_locked = tb_locked;
    assign bus.clk_mon    = tb_mon;

    pll_lock_supervisor #(
        .PLLRST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .LOCK_STABLE(P_STB),
        .WINDOW(P_WIN), .EDGE_MIN(P_EMIN), .EDGE_MAX(P_EMAX)
    ) dut (
        .clk25(clk25),
        .rst  (rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- PLL / clk_mon stimulus ----------------
    int lock_delay = 200;
    int lock_cnt   = 0;
    bit pll_up     = 1'b0;
    bit lock_en    = 1'b1;
    bit glitch     = 1'b0;
    int mon_step   = 3;
    int mon_acc    = 0;
    int cyc        = 0;

    // clk_mon level is a phase accumulator in eighths of a clk25 cycle (step 3 = 9.375 MHz).
    task automatic tick();
        @(negedge clk25);
        cyc++;
        mon_acc = (mon_acc + mon_step) % 8;
        tb_mon  = (mon_acc < 4);
        if (bus.pll_rst === 1'b1) begin
            lock_cnt = 0;
            pll_up   = 1'b0;
        end else if (lock_cnt >= lock_delay) begin
            pll_up = 1'b1;
        end else begin
            lock_cnt++;
        end
        tb_locked = pll_up && lock_en && !glitch;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        chk_en = 1'b1;
        check("reset_state", {bus.pll_rst, bus.domain_rst, bus.ready, bus.meas_edges,
                              bus.retry_cnt, bus.lock_lost_cnt},
              {1'b1, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0});
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_ready(input int budget, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            lat++;
            if (bus.ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Phases count DOWN the cycles left in the current phase.
    localparam int PH_HOLD = 10, PH_WAIT = 11, PH_SETTLE = 12, PH_WIN = 13, PH_LIVE = 14;
    int m_ph, m_left, m_acc, m_meas, m_retry, m_lost;
    logic [1:0] hist_l;
    logic [2:0] hist_m;

    task automatic enter(input int ph);
        m_ph  = ph;
        m_acc = 0;
        case (ph)
            PH_HOLD:   m_left = P_RST;
            PH_WAIT:   m_left = P_TO;
            PH_SETTLE: m_left = P_STB;
            default:   m_left = P_WIN;
        endcase
    endtask

    always @(posedge clk25) begin : model
        bit lk;
        bit ed;
        int cnt;
        if (rst) begin
            enter(PH_HOLD);
            m_meas = 0; m_retry = 0; m_lost = 0;
            hist_l = '0; hist_m = '0;
        end else begin
            lk  = hist_l[1];
            ed  = hist_m[1] && !hist_m[2];
            cnt = (m_acc + int'(ed) > 65535) ? 65535 : m_acc + int'(ed);
            case (m_ph)
                PH_HOLD: if (m_left == 1) enter(PH_WAIT); else m_left--;
                PH_WAIT: begin
                    if (lk) enter(PH_SETTLE);
                    else if (m_left == 1) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        enter(PH_HOLD);
                    end else m_left--;
                end
                PH_SETTLE: begin
                    if (!lk) enter(PH_WAIT);
                    else if (m_left == 1) enter(PH_WIN);
                    else m_left--;
                end
                default: begin
                    if (m_left == 1) m_meas = cnt;
                    if (!lk) begin
                        if (m_ph == PH_LIVE) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                        enter(PH_WAIT);
                    end else if (m_left == 1) begin
                        if (cnt >= P_EMIN && cnt <= P_EMAX) enter(PH_LIVE);
                        else begin
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                            enter(PH_HOLD);
                        end
                    end else begin
                        m_acc = cnt;
                        m_left--;
                    end
                end
            endcase
            hist_l = {hist_l[0], tb_locked};
            hist_m = {hist_m[1:0], tb_mon};
        end
    end

    always @(negedge clk25) begin
        if (chk_en && n_fail < 30) begin
            check("outputs",
                  {29'd0, bus.pll_rst, bus.domain_rst, bus.ready, bus.meas_edges,
                   bus.retry_cnt, bus.lock_lost_cnt},
                  {29'd0, m_ph == PH_HOLD, m_ph != PH_LIVE, m_ph == PH_LIVE, m_meas[15:0],
                   m_retry[7:0], m_lost[7:0]});
        end
    end

    // ---------------- scenarios ----------------
    logic [7:0] exp_q[$];

    initial begin : main
        bit seen;
        int lat, exp_lat, rises, dom_low, hi, drop_left;
        bit prev_rst, rdy_seen;

        // 1: normal lock at 9.375 MHz
        lock_delay = $urandom_range(150, 250);
        mon_acc    = $urandom_range(0, 7);
        apply_reset(3);
        wait_ready(2000, seen, lat);
        check("s1_ready_seen", seen, 1);
        exp_lat = P_RST + 3 + lock_delay + P_STB + P_WIN;
        check("s1_latency", (lat >= exp_lat - 2 && lat <= exp_lat + 2) ? exp_lat : lat, exp_lat);
        check("s1_meas_edges", bus.meas_edges, 96);
        check("s1_retry", bus.retry_cnt, 0);
        repeat ($urandom_range(5, 40)) tick();

        // 5: lock drop in RUN, then relock
        lock_en = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (bus.ready !== 1'b1) break;
        end
        check("s5_drop_latency", lat, 4);
        check("s5_domain_rst", bus.domain_rst, 1);
        check("s5_lock_lost", bus.lock_lost_cnt, 1);
        lock_en = 1'b1;
        wait_ready(1000, seen, lat);
        check("s5_relock_seen", seen, 1);
        check("s5_relock_latency", lat, P_STB + P_WIN + 4);

        // 6: drive lock_lost_cnt to 5, then a one-cycle rst
        for (int k = 0; k < 4; k++) begin
            lock_en = 1'b0;
            repeat ($urandom_range(5, 12)) tick();
            lock_en = 1'b1;
            wait_ready(1000, seen, lat);
            check("s6_relock_seen", seen, 1);
        end
        check("s6_lock_lost_5", bus.lock_lost_cnt, 5);
        rst = 1'b1;
        tick();
        check("s6_counters_cleared", {bus.meas_edges, bus.retry_cnt, bus.lock_lost_cnt}, 0);
        hi = (bus.pll_rst === 1'b1) ? 1 : 0;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.pll_rst === 1'b1) hi++;
            else break;
        end
        check("s6_pll_rst_width", hi, P_RST);
        wait_ready(2000, seen, lat);
        check("s6_resequence_ready", seen, 1);

        // 2: lock never arrives
        lock_en = 1'b0;
        apply_reset(2);
        for (int r = 1; r <= 3; r++) exp_q.push_back(8'(r));
        rises = 0; dom_low = 0; prev_rst = 1'b1;
        repeat (P_RST + 3 * (P_RST + P_TO) + 10) begin
            tick();
            if (bus.pll_rst === 1'b1 && !prev_rst) begin
                rises++;
                if (exp_q.size() > 0) check("s2_retry_step", bus.retry_cnt, exp_q.pop_front());
            end
            prev_rst = bus.pll_rst;
            if (bus.domain_rst !== 1'b1) dom_low++;
        end
        check("s2_rst_pulses", rises, 3);
        check("s2_domain_rst_low", dom_low, 0);
        check("s2_retry_final", bus.retry_cnt, 3);
        lock_en = 1'b1;

        // 3: short lock glitch during STABLE
        lock_delay = $urandom_range(150, 250);
        apply_reset(2);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tb_locked) break;
        end
        repeat (30) tick();
        glitch = 1'b1;
        repeat (3) tick();
        glitch = 1'b0;
        wait_ready(2000, seen, lat);
        check("s3_ready_seen", seen, 1);
        exp_lat = P_RST + 3 + lock_delay + 34 + P_STB + P_WIN;
        check("s3_latency", (cyc >= exp_lat - 2 && cyc <= exp_lat + 2) ? exp_lat : cyc, exp_lat);
        check("s3_retry", bus.retry_cnt, 0);

        // 4: PLL running too fast (12.5 MHz)
        mon_step   = 4;
        lock_delay = $urandom_range(150, 250);
        apply_reset(2);
        rdy_seen = 1'b0;
        repeat (P_RST + 3 + lock_delay + P_STB + P_WIN + 10) begin
            tick();
            if (bus.ready === 1'b1) rdy_seen = 1'b1;
        end
        check("s4_meas_edges", bus.meas_edges, 128);
        check("s4_retry", bus.retry_cnt, 1);
        check("s4_ready_never", rdy_seen, 0);

        // random soak: frequency hops and lock glitches
        mon_step  = 3;
        drop_left = 0;
        apply_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if (i % 128 == 0) begin
                case ($urandom_range(0, 4))
                    0:       mon_step = 2;
                    1:       mon_step = 4;
                    default: mon_step = 3;
                endcase
            end
            if (drop_left == 0 && $urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 4);
            glitch = (drop_left > 0);
            tick();
            if (drop_left > 0) drop_left--;
        end
        check("soak_retry", bus.retry_cnt, 8'(m_retry));
        check("soak_lock_lost", bus.lock_lost_cnt, 8'(m_lost));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #3ms;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
